// File: rtl/chram_arbiter.sv
// chram_arbiter: shares the overlay character RAM between video fetch,
// host writes and a fill engine.
// Ports: clk, reset_n; hcnt/video_addr -> vid_data; host_req/addr/data ->
// host_ack; clr_start/clr_fill -> clr_busy/clr_done; ram_addr/din/we/dout.
module chram_arbiter #(
  parameter int         ADDR_W      = 12,
  parameter int         DATA_W      = 8,
  parameter logic [2:0] VIDEO_PHASE = 3'd0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        hcnt,
  input  logic [ADDR_W-1:0] video_addr,
  output logic [DATA_W-1:0] vid_data,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ack,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_fill,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic {
    IDLE,
    FILL
  } clr_state_t;

  clr_state_t        state;
  clr_state_t        state_nx;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_nx;
  logic [DATA_W-1:0] clr_fill_q;
  logic [DATA_W-1:0] clr_fill_nx;
  logic              clr_done_nx;
  logic              fetch_pend;
  logic              vslot;
  logic              cnt_last;
  logic              hcnt_unused;

  // Only the pixel-within-cell bits matter here.
  assign hcnt_unused = ^hcnt[9:3];

  assign vslot    = (hcnt[2:0] == VIDEO_PHASE);
  assign cnt_last = &clr_cnt;
  assign clr_busy = reset_n && (state == FILL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      clr_fill_q <= '0;
      clr_done   <= 1'b0;
    end else begin
      state      <= state_nx;
      clr_cnt    <= clr_cnt_nx;
      clr_fill_q <= clr_fill_nx;
      clr_done   <= clr_done_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    clr_cnt_nx  = clr_cnt;
    clr_fill_nx = clr_fill_q;
    clr_done_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_start) begin
          state_nx    = FILL;
          clr_cnt_nx  = '0;
          clr_fill_nx = clr_fill;
        end
      end
      FILL: begin
        // A write is issued in every non-video cycle of FILL.
        if (!vslot) begin
          if (cnt_last) begin
            state_nx    = IDLE;
            clr_cnt_nx  = '0;
            clr_done_nx = 1'b1;
          end else begin
            clr_cnt_nx = clr_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  // Port mux; the video slot is never yielded.
  always_comb begin
    ram_addr = video_addr;
    ram_din  = '0;
    ram_we   = 1'b0;
    host_ack = 1'b0;
    if (reset_n) begin
      priority case (1'b1)
        vslot: begin
          ram_addr = video_addr;
        end
        clr_busy: begin
          ram_addr = clr_cnt;
          ram_din  = clr_fill_q;
          ram_we   = 1'b1;
        end
        host_req: begin
          ram_addr = host_addr;
          ram_din  = host_data;
          ram_we   = 1'b1;
          host_ack = 1'b1;
        end
        default: begin
          ram_addr = video_addr;
        end
      endcase
    end
  end

  // RAM read data arrives one cycle after the video slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pend <= 1'b0;
      vid_data   <= '0;
    end else begin
      fetch_pend <= vslot;
      if (fetch_pend) begin
        vid_data <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_chram_arbiter.sv
// tb_chram_arbiter: randomized and directed bench for chram_arbiter
// against a cycle-level behavioural model with its own golden memory.
module tb_chram_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int N  = 4096;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [9:0]    hcnt = '0;
  logic [AW-1:0] video_addr = 12'h0A5;
  logic [DW-1:0] vid_data;
  logic          host_req = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_data = '0;
  logic          host_ack;
  logic          clr_start = 1'b0;
  logic [DW-1:0] clr_fill = '0;
  logic          clr_busy;
  logic          clr_done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [N];
  logic [DW-1:0] gold [N];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  chram_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .hcnt       (hcnt),
    .video_addr (video_addr),
    .vid_data   (vid_data),
    .host_req   (host_req),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .host_ack   (host_ack),
    .clr_start  (clr_start),
    .clr_fill   (clr_fill),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_dout   (ram_dout)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  function automatic logic vs(logic [9:0] h);
    return h[2:0] == 3'd0;
  endfunction

  task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: fill progress as an address counter, video fetch as a
  // one-deep pending value read from the golden memory.
  logic          m_fill;
  int            m_next;
  logic [DW-1:0] m_byte;
  logic          m_done;
  logic          m_pend;
  logic [DW-1:0] m_pval;
  logic [DW-1:0] m_vid;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_fill <= 1'b0;
      m_next <= 0;
      m_byte <= '0;
      m_done <= 1'b0;
      m_pend <= 1'b0;
      m_pval <= '0;
      m_vid  <= '0;
    end else begin
      m_done <= 1'b0;
      if (!vs(hcnt)) begin
        if (m_fill) begin
          gold[m_next] <= m_byte;
          if (m_next == N - 1) begin
            m_fill <= 1'b0;
            m_next <= 0;
            m_done <= 1'b1;
          end else begin
            m_next <= m_next + 1;
          end
        end else if (host_req) begin
          gold[host_addr] <= host_data;
        end
      end
      if (!m_fill && clr_start) begin
        m_fill <= 1'b1;
        m_next <= 0;
        m_byte <= clr_fill;
      end
      if (m_pend) m_vid <= m_pval;
      m_pend <= vs(hcnt);
      if (vs(hcnt)) m_pval <= gold[video_addr];
    end
  end

  always @(negedge clk) begin
    logic          e_we;
    logic          e_ack;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    if (chk_en) begin
      e_we   = 1'b0;
      e_ack  = 1'b0;
      e_addr = video_addr;
      e_din  = '0;
      if (reset_n && !vs(hcnt)) begin
        if (m_fill) begin
          e_we   = 1'b1;
          e_addr = 12'(m_next);
          e_din  = m_byte;
        end else if (host_req) begin
          e_we   = 1'b1;
          e_ack  = 1'b1;
          e_addr = host_addr;
          e_din  = host_data;
        end
      end
      lit("ram_we", 32'(ram_we), 32'(e_we));
      lit("host_ack", 32'(host_ack), 32'(e_ack));
      lit("clr_busy", 32'(clr_busy), 32'(reset_n && m_fill));
      lit("clr_done", 32'(clr_done), 32'(m_done));
      lit("ram_addr", 32'(ram_addr), 32'(e_addr));
      if (e_we || !reset_n) lit("ram_din", 32'(ram_din), 32'(e_din));
      lit("vid_data", 32'(vid_data), 32'(m_vid));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    hcnt = (hcnt == 10'd799) ? 10'd0 : hcnt + 10'd1;
    cyc++;
  endtask

  task automatic align0();
    while (hcnt[2:0] != 3'd0) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int t0, off, first_w, first_a, last_w, done_off, ack_off;
    int done_cnt, bad;
    logic busy_at_done, acked;
    logic [DW-1:0] e8;

    for (int i = 0; i < N; i++) begin
      mem[i]  = 8'(i);
      gold[i] = 8'(i);
    end
    #1 reset_n = 1'b0;
    #1 chk_en = 1'b1;
    step(); step(); step();
    @(negedge clk);
    #3 reset_n = 1'b1;
    #1;
    lit("rst_vid", 32'(vid_data), 32'h0);
    lit("rst_busy", 32'(clr_busy), 32'h0);

    // Video-only: fetch of 0x0A5 in the slot at hcnt=8.
    while (hcnt != 10'd10) step();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lit("video_a5", 32'(vid_data), 32'hA5);
      step();
    end

    // Host writes around the video slot.
    while (hcnt[2:0] != 3'd6) step();
    host_req = 1'b1; host_addr = 12'h123; host_data = 8'h41;
    @(negedge clk);
    lit("ack_ph6", 32'(host_ack), 32'h1);
    step();
    host_req = 1'b0;
    step();
    host_req = 1'b1; host_addr = 12'h124; host_data = 8'h42;
    @(negedge clk);
    lit("ack_vslot", 32'(host_ack), 32'h0);
    step();
    @(negedge clk);
    lit("ack_ph1", 32'(host_ack), 32'h1);
    step();
    host_req = 1'b0;
    @(negedge clk);
    lit("mem_123", 32'(mem[12'h123]), 32'h41);
    lit("mem_124", 32'(mem[12'h124]), 32'h42);

    // Full clear with contention and an ignored restart.
    align0();
    clr_start = 1'b1; clr_fill = 8'h20;
    t0 = cyc;
    first_w = -1; first_a = -1; last_w = -1;
    done_off = -1; ack_off = -1; done_cnt = 0;
    busy_at_done = 1'b1;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      off = cyc - t0;
      if (ram_we && clr_busy && first_w < 0) begin
        first_w = off;
        first_a = int'(ram_addr);
      end
      if (ram_we && clr_busy && ram_addr == 12'hFFF) last_w = off;
      if (clr_done) begin
        done_cnt++;
        if (done_off < 0) begin
          done_off = off;
          busy_at_done = clr_busy;
        end
      end
      if (host_ack && ack_off < 0) ack_off = off;
      if (ack_off >= 0 && done_off >= 0 && off >= done_off + 4) break;
      step();
      off = cyc - t0;
      if (off == 1) clr_start = 1'b0;
      if (off == 10) begin
        host_req = 1'b1; host_addr = 12'h300; host_data = 8'h5A;
      end
      if (off == 2000) begin
        clr_start = 1'b1; clr_fill = 8'hFF;
      end
      if (off == 2001) clr_start = 1'b0;
      if (ack_off >= 0) host_req = 1'b0;
    end
    host_req = 1'b0;
    clr_start = 1'b0;
    lit("first_write_off", 32'(first_w), 32'd1);
    lit("first_write_addr", 32'(first_a), 32'd0);
    lit("last_write_off", 32'(last_w), 32'd4681);
    lit("done_off", 32'(done_off), 32'd4682);
    lit("done_count", 32'(done_cnt), 32'd1);
    lit("busy_at_done", 32'(busy_at_done), 32'd0);
    lit("host_ack_off", 32'(ack_off), 32'd4682);
    bad = 0;
    for (int i = 0; i < N; i++) begin
      e8 = (i == 12'h300) ? 8'h5A : 8'h20;
      if (mem[i] !== e8) bad++;
    end
    lit("fill_image_bad", 32'(bad), 32'd0);

    // Reset in the middle of a clear.
    step();
    align0();
    clr_start = 1'b1; clr_fill = 8'h77;
    step();
    clr_start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (ram_we && clr_busy && ram_addr == 12'd100) break;
      step();
    end
    #3 reset_n = 1'b0;
    #1;
    lit("rst_ram_we", 32'(ram_we), 32'h0);
    lit("rst_ack", 32'(host_ack), 32'h0);
    lit("rst_busy_mid", 32'(clr_busy), 32'h0);
    lit("rst_done", 32'(clr_done), 32'h0);
    lit("rst_vid_mid", 32'(vid_data), 32'h0);
    lit("rst_din", 32'(ram_din), 32'h0);
    lit("rst_addr", 32'(ram_addr), 32'(video_addr));
    step(); step(); step();
    @(negedge clk);
    #3 reset_n = 1'b1;
    #1;
    lit("post_rst_busy", 32'(clr_busy), 32'h0);
    lit("mem_99", 32'(mem[99]), 32'h77);
    lit("mem_100", 32'(mem[100]), 32'h20);
    lit("mem_4095", 32'(mem[4095]), 32'h20);

    align0();
    clr_start = 1'b1; clr_fill = 8'h33;
    step();
    clr_start = 1'b0;
    first_a = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ram_we && clr_busy) begin
        first_a = int'(ram_addr);
        break;
      end
      step();
    end
    lit("restart_addr", 32'(first_a), 32'd0);

    // Random traffic checked against the model.
    for (int k = 0; k < 8000; k++) begin
      @(negedge clk);
      acked = host_ack;
      step();
      video_addr = 12'($urandom);
      clr_start  = ($urandom_range(0, 1999) == 0);
      clr_fill   = 8'($urandom);
      if (host_req) begin
        if (acked) begin
          if ($urandom_range(0, 1) == 1) begin
            host_addr = 12'($urandom);
            host_data = 8'($urandom);
          end else begin
            host_req = 1'b0;
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        host_req  = 1'b1;
        host_addr = 12'($urandom);
        host_data = 8'($urandom);
      end
    end
    host_req = 1'b0;
    clr_start = 1'b0;
    step(); step();
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== gold[i]) bad++;
    lit("mem_vs_model_bad", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
